// File: rtl/targ_uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Holds the state encoding, parity modes and the data-bit clamp helper.
package targ_uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_MAX   = 9;

  // Out-of-range data-bit requests fold onto the nearest legal width.
  function automatic logic [3:0] clamp_bits(input logic [3:0] bits);
    if (bits < 4'd5) return 4'd5;
    if (bits > 4'(DATA_MAX)) return 4'(DATA_MAX);
    return bits;
  endfunction

endpackage

// File: rtl/targ_uart_baud_tick.sv
// Fractional baud accumulator: one-clock tick on every carry out of the
// accumulator, shared with the matching transmitter.
module targ_uart_baud_tick #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACC_WIDTH-1:0] baud_inc,
  output logic                 tick
);

  logic [ACC_WIDTH:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, baud_inc};
  end

  assign tick = acc[ACC_WIDTH];

endmodule

// File: rtl/targ_uart_rx_cfg.sv
// 16x oversampled UART receiver with runtime frame format, error reporting,
// valid/ready output register and idle/end-of-packet gap detection.
module targ_uart_rx_cfg
  import targ_uart_rx_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int IDLE_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  input  logic [ACC_WIDTH-1:0] baud_inc,
  input  logic [3:0]           cfg_data_bits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic [8:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 rx_idle,
  output logic                 rx_endofpacket
);

  // Handshake: a word transfers on any clk where rx_valid && rx_ready; rx_valid
  // never drops without a transfer, and rx_data/flags are stable while it is high.

  localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] GAP_FULL = GW'(GAP_MAX);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

  logic [1:0] rst_ff;
  logic       rst_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_ff <= 2'b00;
    else          rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  logic tick;
  targ_uart_baud_tick #(.ACC_WIDTH(ACC_WIDTH)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_inc (baud_inc),
    .tick     (tick)
  );

  logic [1:0] rxd_ff;
  logic       rxd_s;
  logic [1:0] samp;
  logic       maj;
  assign rxd_s = rxd_ff[1];
  // Vote over the two previous samples and the current one.
  assign maj = (samp[1] & samp[0]) | (samp[1] & rxd_s) | (samp[0] & rxd_s);

  rx_state_e  state, state_next;
  logic [3:0] sc, bit_cnt, f_bits;
  logic [1:0] f_par;
  logic       f_stop2, second_stop, pbit, frame_perr, frame_ferr;
  logic [8:0] data_q;
  logic       mid, par_en, done, brk, done_ferr;

  assign mid       = tick && (sc == 4'(MID_SAMPLE));
  assign par_en    = (f_par != PAR_NONE);
  assign done_ferr = frame_ferr | ~maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    brk        = 1'b0;
    case (state)
      ST_IDLE:   if (tick && !rxd_s) state_next = ST_START;
      ST_START:  if (mid) state_next = maj ? ST_IDLE : ST_DATA;
      ST_DATA:   if (mid && (bit_cnt == f_bits - 4'd1)) state_next = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (mid) state_next = ST_STOP;
      ST_STOP: begin
        if (mid) begin
          if (!maj && !second_stop && (data_q == 9'd0) && !(par_en && pbit)) begin
            brk        = 1'b1;
            state_next = ST_BRK_WAIT;
          end else if (maj && f_stop2 && !second_stop) begin
            state_next = ST_STOP;
          end else begin
            done       = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_BRK_WAIT: if (tick && maj) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_ff      <= 2'b11;
      samp        <= 2'b11;
      sc          <= 4'd0;
      bit_cnt     <= 4'd0;
      f_bits      <= 4'd8;
      f_par       <= PAR_NONE;
      f_stop2     <= 1'b0;
      second_stop <= 1'b0;
      pbit        <= 1'b0;
      frame_perr  <= 1'b0;
      frame_ferr  <= 1'b0;
      data_q      <= 9'd0;
    end else begin
      rxd_ff <= {rxd_ff[0], rxd};
      if (tick) begin
        samp <= {samp[0], rxd_s};
        sc   <= (state == ST_IDLE) ? 4'd0 : sc + 4'd1;
      end
      // Frame format is captured at the start edge so mid-frame cfg writes wait.
      if (state == ST_IDLE && tick && !rxd_s) begin
        f_bits      <= clamp_bits(cfg_data_bits);
        f_par       <= (cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD) ? cfg_parity : PAR_NONE;
        f_stop2     <= cfg_stop2;
        bit_cnt     <= 4'd0;
        second_stop <= 1'b0;
        pbit        <= 1'b0;
        frame_perr  <= 1'b0;
        frame_ferr  <= 1'b0;
        data_q      <= 9'd0;
      end
      if (mid) begin
        case (state)
          ST_DATA: begin
            data_q  <= data_q | (9'(maj) << bit_cnt);
            bit_cnt <= bit_cnt + 4'd1;
          end
          ST_PARITY: begin
            pbit       <= maj;
            frame_perr <= maj ^ (^data_q) ^ (f_par == PAR_ODD);
          end
          ST_STOP: begin
            if (!maj) frame_ferr <= 1'b1;
            if (maj && f_stop2 && !second_stop) second_stop <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= 9'd0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      rx_break   <= brk;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= data_q;
          rx_parity_err <= frame_perr;
          rx_frame_err  <= done_ferr;
          rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
      end
    end
  end

  // Starting saturated keeps reset from looking like the end of a packet.
  logic [GW-1:0] gap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap            <= GAP_FULL;
      rx_endofpacket <= 1'b0;
    end else begin
      rx_endofpacket <= 1'b0;
      if (state != ST_IDLE) begin
        gap <= '0;
      end else if (tick && gap != GAP_FULL) begin
        gap <= gap + 1'b1;
        if (gap == GAP_LAST) rx_endofpacket <= 1'b1;
      end
    end
  end

  assign rx_idle = (gap == GAP_FULL);

endmodule

// File: tb/tb_targ_uart_rx_cfg.sv
// Bench for targ_uart_rx_cfg: table of frame formats plus hand-written
// sequences for ready backpressure, glitches, break, overrun, gap and reset.
module tb_targ_uart_rx_cfg;

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        reset_n, rxd, cfg_stop2, rx_ready;
  logic [15:0] baud_inc;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic [8:0]  rx_data;
  logic        rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_break, rx_idle, rx_endofpacket;

  int tests = 0, fails = 0, brk_cnt = 0, ovr_cnt = 0, eop_cnt = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    logic [3:0] cfg_bits;
    logic [1:0] par;
    logic       stop2;
    logic [8:0] data;
    logic       flip;
    logic       bad2;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[13];

  targ_uart_rx_cfg dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rxd            (rxd),
    .baud_inc       (baud_inc),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity     (cfg_parity),
    .cfg_stop2      (cfg_stop2),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_parity_err  (rx_parity_err),
    .rx_frame_err   (rx_frame_err),
    .rx_overrun     (rx_overrun),
    .rx_break       (rx_break),
    .rx_idle        (rx_idle),
    .rx_endofpacket (rx_endofpacket)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: pop and compare each word at its handshake
  always @(negedge clk) begin
    if (rx_break) brk_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (rx_endofpacket) eop_cnt++;
    if (reset_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", rx_data);
      end else begin
        check("word{data,perr,ferr}", {21'd0, rx_data, rx_parity_err, rx_frame_err}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b, input logic spike);
    rxd = b;
    if (spike) begin
      step(30);
      rxd = ~b;
      step(4);
      rxd = b;
      step(30);
    end else begin
      step(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input logic [1:0] par,
                            input logic stop2, input logic flip, input logic bad2, input int spike_bit);
    logic p;
    p = 1'b0;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(d[i], i == spike_bit);
      p = p ^ d[i];
    end
    if (par == 2'b01 || par == 2'b10) drive_bit(p ^ (par == 2'b10) ^ flip, 1'b0);
    drive_bit(1'b1, 1'b0);
    if (stop2) drive_bit(~bad2, 1'b0);
    rxd = 1'b1;
  endtask

  task automatic set_cfg(input logic [3:0] b, input logic [1:0] p, input logic s2);
    cfg_data_bits = b;
    cfg_parity    = p;
    cfg_stop2     = s2;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("drain_queue_size", exp_q.size(), 0);
  endtask

  function automatic int eff_bits(input logic [3:0] b);
    if (b < 5) return 5;
    if (b > 9) return 9;
    return int'(b);
  endfunction

  initial begin
    int b0, e0, o0;
    logic [8:0] m;

    // vector table: cfg_bits, parity, stop2, data, flip parity, bad stop2, expected
    vecs[0] = '{4'd8,  2'b00, 1'b0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{4'd8,  2'b01, 1'b0, 9'h003, 1'b1, 1'b0, 9'h003, 1'b1, 1'b0};
    vecs[2] = '{4'd8,  2'b01, 1'b0, 9'h003, 1'b0, 1'b0, 9'h003, 1'b0, 1'b0};
    vecs[3] = '{4'd9,  2'b10, 1'b1, 9'h1FF, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b1};
    vecs[4] = '{4'd9,  2'b10, 1'b1, 9'h155, 1'b0, 1'b0, 9'h155, 1'b0, 1'b0};
    vecs[5] = '{4'd5,  2'b00, 1'b0, 9'h015, 1'b0, 1'b0, 9'h015, 1'b0, 1'b0};
    vecs[6] = '{4'd7,  2'b10, 1'b0, 9'h05A, 1'b1, 1'b0, 9'h05A, 1'b1, 1'b0};
    vecs[7] = '{4'd3,  2'b00, 1'b0, 9'h01F, 1'b0, 1'b0, 9'h01F, 1'b0, 1'b0};
    vecs[8] = '{4'd12, 2'b01, 1'b1, 9'h1AB, 1'b0, 1'b0, 9'h1AB, 1'b0, 1'b0};
    vecs[9] = '{4'd8,  2'b11, 1'b0, 9'h080, 1'b0, 1'b0, 9'h080, 1'b0, 1'b0};
    for (int i = 10; i < 13; i++) begin
      vecs[i].cfg_bits = 4'($urandom_range(5, 9));
      m = 9'((1 << eff_bits(vecs[i].cfg_bits)) - 1);
      vecs[i].par      = 2'($urandom_range(0, 3));
      vecs[i].stop2    = 1'($urandom_range(0, 1));
      vecs[i].data     = 9'($urandom_range(0, 511)) & m;
      vecs[i].flip     = 1'b0;
      vecs[i].bad2     = 1'b0;
      vecs[i].exp_data = vecs[i].data;
      vecs[i].exp_perr = 1'b0;
      vecs[i].exp_ferr = 1'b0;
    end

    // reset
    reset_n  = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    baud_inc = 16'd16384;
    set_cfg(4'd8, 2'b00, 1'b0);
    step(5);
    reset_n = 1'b1;
    step(3);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_flags", {rx_parity_err, rx_frame_err, rx_overrun, rx_break}, 0);
    check("reset_rx_idle", rx_idle, 1);
    step(300);
    check("no_eop_after_reset", eop_cnt, 0);

    // 8N1 0xA5 held by rx_ready = 0
    send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    check("hold_valid", rx_valid, 1);
    check("hold_data", rx_data, 9'h0A5);
    check("hold_flags", {rx_parity_err, rx_frame_err}, 0);
    step(100);
    check("hold_still_valid", rx_valid, 1);
    exp_q.push_back({9'h0A5, 1'b0, 1'b0});
    rx_ready = 1'b1;
    step(1);
    check("valid_cleared_after_handshake", rx_valid, 0);

    // table-driven frame formats
    for (int i = 0; i < 13; i++) begin
      set_cfg(vecs[i].cfg_bits, vecs[i].par, vecs[i].stop2);
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      send_frame(vecs[i].data, eff_bits(vecs[i].cfg_bits), vecs[i].par, vecs[i].stop2,
                 vecs[i].flip, vecs[i].bad2, -1);
      wait_drain(200);
      step(40);
    end

    // glitch on idle line: false start, no word
    set_cfg(4'd8, 2'b00, 1'b0);
    rxd = 1'b0;
    step(8);
    rxd = 1'b1;
    step(300);
    check("glitch_no_valid", rx_valid, 0);
    // single-sample spike inside data bit 3 of 0x00
    exp_q.push_back({9'h000, 1'b0, 1'b0});
    send_frame(9'h000, 8, 2'b00, 1'b0, 1'b0, 1'b0, 3);
    wait_drain(200);
    step(40);

    // break: 20 bit-times low, then a normal word
    b0 = brk_cnt;
    rxd = 1'b0;
    step(20 * BIT_CLKS);
    rxd = 1'b1;
    step(200);
    check("break_pulse_count", brk_cnt - b0, 1);
    check("break_no_valid", rx_valid, 0);
    exp_q.push_back({9'h041, 1'b0, 1'b0});
    send_frame(9'h041, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    wait_drain(200);
    step(40);

    // overrun: second word dropped while first waits
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(9'h011, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    send_frame(9'h022, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    check("overrun_kept_data", rx_data, 9'h011);
    check("overrun_pulse_count", ovr_cnt - o0, 1);
    exp_q.push_back({9'h011, 1'b0, 1'b0});
    rx_ready = 1'b1;
    wait_drain(20);
    step(1);
    check("overrun_drained_valid", rx_valid, 0);
    step(400);

    // gap: one end-of-packet pulse 32 ticks after the last frame
    exp_q.push_back({9'h05C, 1'b0, 1'b0});
    send_frame(9'h05C, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    e0 = eop_cnt;
    check("gap_not_idle_yet", rx_idle, 0);
    step(200);
    check("gap_eop_once", eop_cnt - e0, 1);
    check("gap_idle", rx_idle, 1);
    step(300);
    check("gap_eop_still_once", eop_cnt - e0, 1);
    wait_drain(10);

    // reset mid-frame with a pending word
    rx_ready = 1'b0;
    send_frame(9'h022, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    check("pre_reset_valid", rx_valid, 1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_pulses_flags",
          {rx_parity_err, rx_frame_err, rx_overrun, rx_break, rx_endofpacket}, 0);
    check("midreset_rx_idle", rx_idle, 1);
    rxd = 1'b1;
    step(4);
    reset_n = 1'b1;
    e0 = eop_cnt;
    step(300);
    check("post_reset_no_eop", eop_cnt - e0, 0);
    check("post_reset_no_valid", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
